fpcmp_gen: RTL and testbench

FPCMP_GEN -- requirements
Module: fpcmp_gen

---
 rtl/fpcmp_gen.sv | 209 ++++++++++++++++++++
 tb/tb_fpcmp_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fpcmp_gen.sv
// fpcmp_gen -- multi-cycle compare / min / max unit for IEEE-754-format
// operands of any exponent/fraction width.
//
// A request is accepted from IDLE or DONE while run is high. The operands
// are captured, classified (NaN / signaling NaN) in CLASS, and the result
// is evaluated in CMP and registered into z/r/flags on the CMP->DONE edge.
// Dropping run in CLASS or CMP abandons the request without touching the
// outputs.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (returns to IDLE, clears z/r/flags)
//   run    request; hold high with stable operands until stall is low
//   stall  high while run is high and the result is not yet valid
//   mode   00 compare, 01 min, 10 max, 11 compare
//   pred   compare predicate (EQ, NE, LT/LE signaling, UN, LT/LE quiet, ORD)
//   x, y   operands {sign, exponent, fraction}
//   z      predicate result (0 in min/max mode)
//   r      min/max result (held in compare mode)
//   flags  {invalid, divzero, overflow, underflow, inexact}
module fpcmp_gen #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic                  stall,
  input  logic [1:0]            mode,
  input  logic [2:0]            pred,
  input  logic [EXP_W+FRAC_W:0] x,
  input  logic [EXP_W+FRAC_W:0] y,
  output logic                  z,
  output logic [EXP_W+FRAC_W:0] r,
  output logic [4:0]            flags
);

  localparam int W = 1 + EXP_W + FRAC_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLASS = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, {FRAC_W{1'b0}}} | ({{(W-1){1'b0}}, 1'b1} << (FRAC_W - 1));

  // NaN: exponent all ones with a nonzero fraction.
  function automatic logic is_nan(input logic [W-1:0] v);
    return (&v[W-2:FRAC_W]) && (|v[FRAC_W-1:0]);
  endfunction

  // Signaling NaN: a NaN whose fraction MSB (quiet bit) is clear.
  function automatic logic is_snan(input logic [W-1:0] v);
    return is_nan(v) && !v[FRAC_W-1];
  endfunction

  logic [1:0]   state_q, state_d;
  logic [1:0]   mode_q, mode_d;
  logic [2:0]   pred_q, pred_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic         x_nan_q, x_nan_d, y_nan_q, y_nan_d;
  logic         x_snan_q, x_snan_d, y_snan_q, y_snan_d;
  logic         z_q, z_d;
  logic [W-1:0] r_q, r_d;
  logic [4:0]   flags_q, flags_d;

  logic         unord_s, both_zero_s, eq_s, lt_s, mm_lt_s;
  logic         sig_s, cmp_z_s, mm_s, invalid_s;
  logic [W-1:0] mm_r_s;

  // Result evaluation from the captured operands and their classification.
  always_comb begin
    unord_s     = x_nan_q || y_nan_q;
    both_zero_s = (x_q[W-2:0] == {(W-1){1'b0}}) && (y_q[W-2:0] == {(W-1){1'b0}});
    eq_s        = !unord_s && (both_zero_s || (x_q == y_q));
    // Ordering uses magnitude {exponent,fraction}; for negatives the larger
    // magnitude is the smaller value. For min/max, -0 sorts below +0, so the
    // differing-sign case ignores the both-zero exception.
    if (x_q[W-1] != y_q[W-1]) begin
      lt_s    = x_q[W-1] && !both_zero_s;
      mm_lt_s = x_q[W-1];
    end else if (x_q[W-1]) begin
      lt_s    = x_q[W-2:0] > y_q[W-2:0];
      mm_lt_s = lt_s;
    end else begin
      lt_s    = x_q[W-2:0] < y_q[W-2:0];
      mm_lt_s = lt_s;
    end

    sig_s = 1'b0;
    case (pred_q)
      3'b000:  cmp_z_s = eq_s;
      3'b001:  cmp_z_s = !eq_s;
      3'b010:  begin cmp_z_s = !unord_s && lt_s;          sig_s = 1'b1; end
      3'b011:  begin cmp_z_s = !unord_s && (lt_s || eq_s); sig_s = 1'b1; end
      3'b100:  cmp_z_s = unord_s;
      3'b101:  cmp_z_s = !unord_s && lt_s;
      3'b110:  cmp_z_s = !unord_s && (lt_s || eq_s);
      3'b111:  cmp_z_s = !unord_s;
      default: cmp_z_s = 1'b0;
    endcase

    mm_s = (mode_q == 2'b01) || (mode_q == 2'b10);
    // Signaling predicates raise invalid on any NaN, but only in compare mode.
    invalid_s = x_snan_q || y_snan_q || (!mm_s && sig_s && unord_s);

    if (x_nan_q && y_nan_q) begin
      mm_r_s = QNAN;
    end else if (x_nan_q) begin
      mm_r_s = y_q;
    end else if (y_nan_q) begin
      mm_r_s = x_q;
    end else if (mode_q == 2'b10) begin
      mm_r_s = mm_lt_s ? y_q : x_q;
    end else begin
      mm_r_s = mm_lt_s ? x_q : y_q;
    end
  end

  // Next-state and datapath-register update for the IDLE/CLASS/CMP/DONE sequence.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pred_d   = pred_q;
    x_d      = x_q;
    y_d      = y_q;
    x_nan_d  = x_nan_q;
    y_nan_d  = y_nan_q;
    x_snan_d = x_snan_q;
    y_snan_d = y_snan_q;
    z_d      = z_q;
    r_d      = r_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          state_d = S_CLASS;
          mode_d  = mode;
          pred_d  = pred;
          x_d     = x;
          y_d     = y;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLASS: begin
        if (run) begin
          state_d  = S_CMP;
          x_nan_d  = is_nan(x_q);
          y_nan_d  = is_nan(y_q);
          x_snan_d = is_snan(x_q);
          y_snan_d = is_snan(y_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CMP: begin
        if (run) begin
          state_d = S_DONE;
          z_d     = mm_s ? 1'b0 : cmp_z_s;
          r_d     = mm_s ? mm_r_s : r_q;
          flags_d = {invalid_s, 4'b0000};
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'b00;
      pred_q   <= 3'b000;
      x_q      <= {W{1'b0}};
      y_q      <= {W{1'b0}};
      x_nan_q  <= 1'b0;
      y_nan_q  <= 1'b0;
      x_snan_q <= 1'b0;
      y_snan_q <= 1'b0;
      z_q      <= 1'b0;
      r_q      <= {W{1'b0}};
      flags_q  <= 5'b00000;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pred_q   <= pred_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x_nan_q  <= x_nan_d;
      y_nan_q  <= y_nan_d;
      x_snan_q <= x_snan_d;
      y_snan_q <= y_snan_d;
      z_q      <= z_d;
      r_q      <= r_d;
      flags_q  <= flags_d;
    end
  end

  assign stall = run && (state_q != S_DONE);
  assign z     = z_q;
  assign r     = r_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fpcmp_gen.sv
// Directed testbench for fpcmp_gen: a single-precision instance (default
// parameters) and a double-precision instance (EXP_W=11, FRAC_W=52).
module tb_fpcmp_gen;

  logic clk;
  logic rst_n;

  logic        run_sp, stall_sp, z_sp;
  logic [1:0]  mode_sp;
  logic [2:0]  pred_sp;
  logic [31:0] x_sp, y_sp, r_sp;
  logic [4:0]  flags_sp;

  logic        run_dp, stall_dp, z_dp;
  logic [1:0]  mode_dp;
  logic [2:0]  pred_dp;
  logic [63:0] x_dp, y_dp, r_dp;
  logic [4:0]  flags_dp;

  int n_cmp;
  int n_bad;

  fpcmp_gen u_sp (
    .clk(clk), .rst_n(rst_n), .run(run_sp), .stall(stall_sp), .mode(mode_sp),
    .pred(pred_sp), .x(x_sp), .y(y_sp), .z(z_sp), .r(r_sp), .flags(flags_sp)
  );

  fpcmp_gen #(.EXP_W(11), .FRAC_W(52)) u_dp (
    .clk(clk), .rst_n(rst_n), .run(run_dp), .stall(stall_dp), .mode(mode_dp),
    .pred(pred_dp), .x(x_dp), .y(y_dp), .z(z_dp), .r(r_dp), .flags(flags_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one single-precision request from a falling edge, record stall
  // after each of the three following rising edges, then release run.
  task automatic op_sp(input logic [1:0] m, input logic [2:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [2:0] st);
    @(negedge clk);
    mode_sp = m; pred_sp = p; x_sp = a; y_sp = b; run_sp = 1'b1;
    @(negedge clk); st[2] = stall_sp;
    @(negedge clk); st[1] = stall_sp;
    @(negedge clk); st[0] = stall_sp;
    run_sp = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_sp = 1'b0; run_dp = 1'b0;
    mode_sp = 2'b00; pred_sp = 3'b000; x_sp = 32'h0; y_sp = 32'h0;
    mode_dp = 2'b00; pred_dp = 3'b000; x_dp = 64'h0; y_dp = 64'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL rst_z: got %b want 0", z_sp); end
    n_cmp++; if (r_sp !== 32'h0) begin n_bad++; $display("FAIL rst_r: got %h want 00000000", r_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL rst_flags: got %h want 00", flags_sp); end
    n_cmp++; if (stall_sp !== 1'b0) begin n_bad++; $display("FAIL rst_stall_idle: got %b want 0", stall_sp); end
    n_cmp++; if (r_dp !== 64'h0) begin n_bad++; $display("FAIL rst_r_dp: got %h want 0", r_dp); end
    run_sp = 1'b1;
    #1;
    n_cmp++; if (stall_sp !== 1'b1) begin n_bad++; $display("FAIL rst_stall_run: got %b want 1", stall_sp); end
    run_sp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lt();
    logic [2:0] st;
    op_sp(2'b00, 3'b010, 32'h3F800000, 32'h40000000, st);
    n_cmp++; if (st !== 3'b110) begin n_bad++; $display("FAIL lt_stall: got %b want 110", st); end
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL lt_z: got %b want 1", z_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL lt_flags: got %h want 00", flags_sp); end
    n_cmp++; if (r_sp !== 32'h0) begin n_bad++; $display("FAIL lt_r_held: got %h want 00000000", r_sp); end
    // -2 < -1 exercises the negative-magnitude ordering.
    op_sp(2'b00, 3'b101, 32'hC0000000, 32'hBF800000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL lt_neg_z: got %b want 1", z_sp); end
    op_sp(2'b00, 3'b101, 32'h40000000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL lt_false_z: got %b want 0", z_sp); end
  endtask

  task automatic test_zero_eq();
    logic [2:0] st;
    op_sp(2'b00, 3'b000, 32'h00000000, 32'h80000000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL zero_eq_z: got %b want 1", z_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL zero_eq_flags: got %h want 00", flags_sp); end
    op_sp(2'b00, 3'b001, 32'h00000000, 32'h80000000, st);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL zero_ne_z: got %b want 0", z_sp); end
    op_sp(2'b00, 3'b110, 32'h80000000, 32'h00000000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL zero_le_z: got %b want 1", z_sp); end
  endtask

  task automatic test_nan_cmp();
    logic [2:0] st;
    op_sp(2'b00, 3'b010, 32'h7FC00000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL qnan_lt_z: got %b want 0", z_sp); end
    n_cmp++; if (flags_sp !== 5'h10) begin n_bad++; $display("FAIL qnan_lt_flags: got %h want 10", flags_sp); end
    op_sp(2'b00, 3'b000, 32'h7FC00000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL qnan_eq_z: got %b want 0", z_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL qnan_eq_flags: got %h want 00", flags_sp); end
    op_sp(2'b00, 3'b100, 32'h7FC00000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL qnan_un_z: got %b want 1", z_sp); end
    op_sp(2'b00, 3'b001, 32'h7FC00000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL qnan_ne_z: got %b want 1", z_sp); end
    op_sp(2'b00, 3'b000, 32'h7F800001, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL snan_eq_z: got %b want 0", z_sp); end
    n_cmp++; if (flags_sp !== 5'h10) begin n_bad++; $display("FAIL snan_eq_flags: got %h want 10", flags_sp); end
    // Infinity is not a NaN.
    op_sp(2'b00, 3'b111, 32'h7F800000, 32'h3F800000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL inf_ord_z: got %b want 1", z_sp); end
  endtask

  task automatic test_minmax();
    logic [2:0] st;
    op_sp(2'b01, 3'b000, 32'h7FC00000, 32'hC0000000, st);
    n_cmp++; if (r_sp !== 32'hC0000000) begin n_bad++; $display("FAIL min_nan_r: got %h want C0000000", r_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL min_nan_flags: got %h want 00", flags_sp); end
    op_sp(2'b10, 3'b100, 32'h80000000, 32'h00000000, st);
    n_cmp++; if (r_sp !== 32'h00000000) begin n_bad++; $display("FAIL max_zero_r: got %h want 00000000", r_sp); end
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL max_zero_z: got %b want 0", z_sp); end
    op_sp(2'b01, 3'b000, 32'h00000000, 32'h80000000, st);
    n_cmp++; if (r_sp !== 32'h80000000) begin n_bad++; $display("FAIL min_zero_r: got %h want 80000000", r_sp); end
    op_sp(2'b10, 3'b000, 32'h3F800000, 32'h40000000, st);
    n_cmp++; if (r_sp !== 32'h40000000) begin n_bad++; $display("FAIL max_r: got %h want 40000000", r_sp); end
    op_sp(2'b01, 3'b000, 32'h7FC00000, 32'h7F800001, st);
    n_cmp++; if (r_sp !== 32'h7FC00000) begin n_bad++; $display("FAIL min_2nan_r: got %h want 7FC00000", r_sp); end
    n_cmp++; if (flags_sp !== 5'h10) begin n_bad++; $display("FAIL min_2nan_flags: got %h want 10", flags_sp); end
    // Reserved mode behaves as compare and leaves r alone.
    op_sp(2'b11, 3'b111, 32'h3F800000, 32'h40000000, st);
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL mode11_z: got %b want 1", z_sp); end
    n_cmp++; if (r_sp !== 32'h7FC00000) begin n_bad++; $display("FAIL mode11_r_held: got %h want 7FC00000", r_sp); end
  endtask

  task automatic test_reset_in_cmp();
    logic [2:0] st;
    @(negedge clk);
    mode_sp = 2'b00; pred_sp = 3'b010; x_sp = 32'h3F800000; y_sp = 32'h40000000; run_sp = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (z_sp !== 1'b0) begin n_bad++; $display("FAIL rcmp_z: got %b want 0", z_sp); end
    n_cmp++; if (r_sp !== 32'h0) begin n_bad++; $display("FAIL rcmp_r: got %h want 00000000", r_sp); end
    n_cmp++; if (flags_sp !== 5'h00) begin n_bad++; $display("FAIL rcmp_flags: got %h want 00", flags_sp); end
    n_cmp++; if (stall_sp !== 1'b1) begin n_bad++; $display("FAIL rcmp_stall: got %b want 1", stall_sp); end
    rst_n = 1'b1;
    @(negedge clk); st[2] = stall_sp;
    @(negedge clk); st[1] = stall_sp;
    @(negedge clk); st[0] = stall_sp;
    n_cmp++; if (st !== 3'b110) begin n_bad++; $display("FAIL rcmp_restart_stall: got %b want 110", st); end
    n_cmp++; if (z_sp !== 1'b1) begin n_bad++; $display("FAIL rcmp_restart_z: got %b want 1", z_sp); end
    run_sp = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] st;
    @(negedge clk);
    mode_dp = 2'b00; pred_dp = 3'b011;
    x_dp = 64'h3FF0000000000000; y_dp = 64'hBFF0000000000000; run_dp = 1'b1;
    @(negedge clk); st[2] = stall_dp;
    @(negedge clk); st[1] = stall_dp;
    @(negedge clk); st[0] = stall_dp;
    n_cmp++; if (st !== 3'b110) begin n_bad++; $display("FAIL dp_first_stall: got %b want 110", st); end
    n_cmp++; if (z_dp !== 1'b0) begin n_bad++; $display("FAIL dp_first_z: got %b want 0", z_dp); end
    n_cmp++; if (flags_dp !== 5'h00) begin n_bad++; $display("FAIL dp_first_flags: got %h want 00", flags_dp); end
    x_dp = 64'hBFF0000000000000; y_dp = 64'h3FF0000000000000;
    @(negedge clk); st[2] = stall_dp;
    @(negedge clk); st[1] = stall_dp;
    @(negedge clk); st[0] = stall_dp;
    n_cmp++; if (st !== 3'b110) begin n_bad++; $display("FAIL dp_b2b_stall: got %b want 110", st); end
    n_cmp++; if (z_dp !== 1'b1) begin n_bad++; $display("FAIL dp_b2b_z: got %b want 1", z_dp); end
    n_cmp++; if (r_dp !== 64'h0) begin n_bad++; $display("FAIL dp_b2b_r_held: got %h want 0", r_dp); end
    run_dp = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_lt();
    test_zero_eq();
    test_nan_cmp();
    test_minmax();
    test_reset_in_cmp();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
